bd_line_compressor: RTL and testbench
=====================================

Name: bd_line_compressor

Overview:
- Write-side counterpart of the compressed-line request filter. Takes an uncompressed 512-bit cache line (16 x 32-bit words) plus its 64-bit tag and produces the 644-bit base-delta compressed line word that the filter later decodes.
- Scans one word per cycle, selects the smallest legal encoding, packs the payload, and presents it with a valid/ready handshake.
- Sits between the fill path and the compressed data array.

Parameters:
- NWORDS, 16, words per line; fixed, since wordaddr is 4 bits.
- WORDW, 32, word width in bits.

Ports:
- clk  input  1  clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  line offered.
- in_ready  output  1  block can accept a line.
- in_line  input  512  uncompressed line; word i = in_line[32*i +: 32].
- in_tag  input  64  line tag.
- out_valid  output  1  compressed line available.
- out_ready  input  1  consumer accepts the compressed line.
- out_d  output  644  compressed line word.
- out_tag  output  64  tag passed through with the line.

Behaviour:
- Line format:
  - out_d[2:0] = encoding code.
  - out_d[3] = con (valid line), always 1 on output.
  - out_d[643:4] = payload P[639:0]; unused payload bits are 0.
- Codes, in selection priority order:
  - 000 all-zero: P = 0.
  - 001 repeated: P[31:0] = word0.
  - 010 base4-delta1: P[31:0] = base = word0; P[32+8*i +: 8] = delta_i.
  - 011 base4-delta2: P[31:0] = base; P[32+16*i +: 16] = delta_i.
  - 111 uncompressed: P[511:0] = line.
  - 100, 101 and 110 are reserved and never emitted.
- Delta arithmetic: delta_i = (word_i - base) mod 2^32.
  - Fits width w iff bits [31:w-1] of delta_i are all equal (signed two's-complement range).
  - delta_0 is always 0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch in_line and in_tag.
  - Set flags zero_ok, rep_ok, d1_ok, d2_ok all to 1 and idx to 0, then go to SCAN.
- SCAN:
  - in_ready = 0.
  - Each cycle, test word[idx] against the flags:
    - zero_ok &= (word == 0)
    - rep_ok &= (word == word0)
    - d1_ok &= fits8
    - d2_ok &= fits16
  - idx increments by 1.
  - At idx == 15, use the next-state flags to select the code, register out_d and out_tag, set out_valid = 1, and go to DONE.
- Latency: exactly 16 cycles from the accepting edge to the edge that raises out_valid.
- DONE:
  - out_valid = 1; out_d and out_tag are held stable.
  - On out_valid & out_ready, clear out_valid and go to IDLE.
  - in_ready rises the following cycle; there is no same-cycle turnaround.
- Throughput: one line per 18 cycles minimum.
- Backpressure: out_ready low holds DONE indefinitely with no change in outputs.
- in_valid is ignored outside IDLE; a line offered during SCAN or DONE is not latched.
- idx is 4 bits; the idx == 15 terminal value is used, so no wrap-around occurs.
- Reset values (reset_n low, at any time including mid-SCAN or in DONE):
  - state = IDLE, in_ready = 1 after release, out_valid = 0, out_d = 0, out_tag = 0, idx = 0, all flags = 1.
  - Any in-flight line is discarded.

Decomposition:
- Package bd_pkg holds:
  - Code constants: CODE_ZERO = 3'b000, CODE_REP = 3'b001, CODE_B4D1 = 3'b010, CODE_B4D2 = 3'b011, CODE_RAW = 3'b111.
  - Field offsets: CODE_LSB = 0, CON_BIT = 3, PAYLOAD_LSB = 4.
  - LINEW = 644, TAGW = 64.
  - State enum type.
- One natural sub-module, bd_delta_check:
  - Combinational: inputs word and base; outputs is_zero, eq_base, fits8, fits16.
  - The request filter's decode path reuses it for consistency.

Test Plan:
- All-zero line, tag 64'hAAAAAAAAAAAAAAA0 -> after 16 cycles out_valid = 1, out_d[2:0] = 000, out_d[3] = 1, out_d[643:4] = 0, out_tag = AAAAAAAAAAAAAAA0.
- All words 32'h55555555 -> code 001, P[31:0] = 55555555, rest of P = 0.
- word_i = 32'h1000_0000 + i - 3 (deltas from -0 up to +15 relative to the first word) -> code 010, base 0FFFFFFD, delta_i byte = i.
- Boundary deltas, with base = 32'h0000_1000:
  - word_i = base - 128 on one word -> code 010 (fits8).
  - word_i = base + 128 on one word -> code 011 with delta 16'h0080.
  - word_i = base + 32768 on one word -> code 111, P[511:0] = line.
- Backpressure and handshake:
  - Hold out_ready = 0 for 10 cycles in DONE -> out_d and out_valid stable, in_ready = 0.
  - Assert out_ready -> out_valid drops next edge; in_ready = 1 the cycle after.
  - in_valid asserted during SCAN -> ignored.
- Reset mid-operation: assert reset_n = 0 at SCAN idx = 7, asynchronously mid-cycle -> out_valid = 0 and in_ready = 1 immediately after release; a new line accepted afterwards compresses correctly with no residue from the aborted line.

Source files
------------

// File: rtl/bd_pkg.sv
// Base-delta line compression: shared codes, field offsets, line layout and packing helpers.
// Latency: n/a (types, constants and combinational functions only).
// Backpressure: n/a.
package bd_pkg;

  // Encoding codes in selection priority order; 100/101/110 are reserved.
  localparam logic [2:0] CODE_ZERO = 3'b000;
  localparam logic [2:0] CODE_REP  = 3'b001;
  localparam logic [2:0] CODE_B4D1 = 3'b010;
  localparam logic [2:0] CODE_B4D2 = 3'b011;
  localparam logic [2:0] CODE_RAW  = 3'b111;

  // Compressed line word layout.
  localparam int CODE_LSB    = 0;
  localparam int CON_BIT     = 3;
  localparam int PAYLOAD_LSB = 4;
  localparam int LINEW       = 644;
  localparam int TAGW        = 64;
  localparam int PAYW        = LINEW - PAYLOAD_LSB;
  localparam int RAWW        = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Packed view of the compressed line word: code in [2:0], con in [3], payload above.
  typedef struct packed {
    logic [PAYW-1:0] payload;
    logic            con;
    logic [2:0]      code;
  } cline_t;

  // Smallest legal encoding given the per-line qualification flags.
  function automatic logic [2:0] select_code(input logic zero_ok, input logic rep_ok,
                                             input logic d1_ok, input logic d2_ok);
    logic [2:0] code;
    if (zero_ok)     code = CODE_ZERO;
    else if (rep_ok) code = CODE_REP;
    else if (d1_ok)  code = CODE_B4D1;
    else if (d2_ok)  code = CODE_B4D2;
    else             code = CODE_RAW;
    return code;
  endfunction

  // Payload for a chosen code. Base is always word0; deltas are the low bits of
  // (word_i - base), which the scan has already proven fit the chosen width.
  function automatic logic [PAYW-1:0] pack_payload(input logic [2:0] code,
                                                   input logic [RAWW-1:0] line);
    logic [PAYW-1:0] p;
    logic [31:0]     base;
    logic [31:0]     d;
    p    = '0;
    base = line[31:0];
    d    = '0;
    case (code)
      CODE_REP: p[31:0] = base;
      CODE_B4D1: begin
        p[31:0] = base;
        for (int i = 0; i < 16; i++) begin
          d = line[32*i +: 32] - base;
          p[32 + 8*i +: 8] = d[7:0];
        end
      end
      CODE_B4D2: begin
        p[31:0] = base;
        for (int i = 0; i < 16; i++) begin
          d = line[32*i +: 32] - base;
          p[32 + 16*i +: 16] = d[15:0];
        end
      end
      CODE_RAW: p[RAWW-1:0] = line;
      default:  p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/bd_delta_check.sv
// Per-word qualification against a base word: zero, equal-to-base, delta fits 8 / 16 bits signed.
// Latency: combinational.
// Backpressure: none.
// Ports: word, base (32b) in; is_zero, eq_base, fits8, fits16 out.
module bd_delta_check (
  input  logic [31:0] word,
  input  logic [31:0] base,
  output logic        is_zero,
  output logic        eq_base,
  output logic        fits8,
  output logic        fits16
);

  logic [31:0] delta;

  assign delta   = word - base;
  assign is_zero = (word == 32'd0);
  assign eq_base = (word == base);
  // A delta fits w signed bits when bits [31:w-1] are a pure sign extension.
  assign fits8   = (&delta[31:7])  | ~(|delta[31:7]);
  assign fits16  = (&delta[31:15]) | ~(|delta[31:15]);

endmodule

// File: rtl/bd_line_compressor.sv
// Compresses a 16x32b line + tag into a 644b base-delta line word, one word scanned per cycle.
// Latency: 16 cycles from the accepting edge to out_valid; one line per 18 cycles at best.
// Backpressure: out_ready low holds DONE with outputs frozen; in_ready is high only in IDLE.
// Ports: clk, reset_n; in_valid/in_ready/in_line/in_tag; out_valid/out_ready/out_d/out_tag.
module bd_line_compressor
  import bd_pkg::*;
#(
  parameter int NWORDS = 16,
  parameter int WORDW  = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NWORDS*WORDW-1:0] in_line,
  input  logic [TAGW-1:0]         in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LINEW-1:0]        out_d,
  output logic [TAGW-1:0]         out_tag
);

  state_t                         state_q, state_n;
  logic [NWORDS-1:0][WORDW-1:0]   line_q;
  logic [TAGW-1:0]                tag_q;
  logic [3:0]                     idx_q;
  logic                           zero_ok_q, rep_ok_q, d1_ok_q, d2_ok_q;
  logic                           zero_ok_n, rep_ok_n, d1_ok_n, d2_ok_n;
  logic                           out_valid_q;
  cline_t                         out_d_q;
  logic [TAGW-1:0]                out_tag_q;

  logic                           accept, scan_last, done_take;
  logic                           w_zero, w_eq, w_fits8, w_fits16;
  logic [2:0]                     code_sel;

  bd_delta_check u_chk (
    .word    (line_q[idx_q]),
    .base    (line_q[0]),
    .is_zero (w_zero),
    .eq_base (w_eq),
    .fits8   (w_fits8),
    .fits16  (w_fits16)
  );

  // Flags including the word under test; on the last word these decide the code.
  assign zero_ok_n = zero_ok_q & w_zero;
  assign rep_ok_n  = rep_ok_q  & w_eq;
  assign d1_ok_n   = d1_ok_q   & w_fits8;
  assign d2_ok_n   = d2_ok_q   & w_fits16;
  assign code_sel  = select_code(zero_ok_n, rep_ok_n, d1_ok_n, d2_ok_n);

  always_comb begin
    state_n   = state_q;
    in_ready  = 1'b0;
    accept    = 1'b0;
    scan_last = 1'b0;
    done_take = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (idx_q == 4'd15) begin
          scan_last = 1'b1;
          state_n   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          done_take = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      line_q      <= '0;
      tag_q       <= '0;
      idx_q       <= 4'd0;
      zero_ok_q   <= 1'b1;
      rep_ok_q    <= 1'b1;
      d1_ok_q     <= 1'b1;
      d2_ok_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_d_q     <= '0;
      out_tag_q   <= '0;
    end else begin
      state_q <= state_n;
      if (accept) begin
        line_q    <= in_line;
        tag_q     <= in_tag;
        idx_q     <= 4'd0;
        zero_ok_q <= 1'b1;
        rep_ok_q  <= 1'b1;
        d1_ok_q   <= 1'b1;
        d2_ok_q   <= 1'b1;
      end else if (state_q == SCAN) begin
        zero_ok_q <= zero_ok_n;
        rep_ok_q  <= rep_ok_n;
        d1_ok_q   <= d1_ok_n;
        d2_ok_q   <= d2_ok_n;
        // idx parks at 15 on the last word instead of wrapping; accept reloads it.
        if (scan_last) begin
          out_d_q     <= '{payload: pack_payload(code_sel, line_q), con: 1'b1, code: code_sel};
          out_tag_q   <= tag_q;
          out_valid_q <= 1'b1;
        end else begin
          idx_q <= idx_q + 4'd1;
        end
      end
      if (done_take) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_d     = out_d_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_bd_line_compressor.sv
module tb_bd_line_compressor;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [511:0]  in_line;
  logic [63:0]   in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [643:0]  out_d;
  logic [63:0]   out_tag;

  typedef struct packed {
    logic [643:0] d;
    logic [63:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   checks;
  int   failures;
  int   cyc;
  bit   force_mode;
  bit   force_val;

  bd_line_compressor dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_line   (in_line),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d     (out_d),
    .out_tag   (out_tag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Consumer: random readiness unless the main sequence forces a level.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = force_mode ? force_val : ($urandom_range(0, 3) != 0);
    end
  end

  // Reference model: choose the smallest encoding from signed word deltas.
  function automatic logic [643:0] model(input logic [511:0] line);
    logic [31:0]        w0, w;
    logic signed [31:0] diff;
    bit                 z, r, ok8, ok16;
    logic [639:0]       p;
    logic [2:0]         code;
    w0 = line[31:0];
    z = 1; r = 1; ok8 = 1; ok16 = 1;
    for (int i = 0; i < 16; i++) begin
      w    = line[32*i +: 32];
      diff = w - w0;
      if (w != 32'd0) z = 0;
      if (w != w0) r = 0;
      if (diff < -128 || diff > 127) ok8 = 0;
      if (diff < -32768 || diff > 32767) ok16 = 0;
    end
    p = '0;
    if (z) begin
      code = 3'b000;
    end else if (r) begin
      code = 3'b001;
      p[31:0] = w0;
    end else if (ok8) begin
      code = 3'b010;
      p[31:0] = w0;
      for (int i = 0; i < 16; i++) begin
        diff = line[32*i +: 32] - w0;
        p[32 + 8*i +: 8] = diff[7:0];
      end
    end else if (ok16) begin
      code = 3'b011;
      p[31:0] = w0;
      for (int i = 0; i < 16; i++) begin
        diff = line[32*i +: 32] - w0;
        p[32 + 16*i +: 16] = diff[15:0];
      end
    end else begin
      code = 3'b111;
      p[511:0] = line;
    end
    return {p, 1'b1, code};
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    logic [31:0]  base;
    int           kind, off;
    kind = $urandom_range(0, 6);
    base = $urandom;
    l    = '0;
    for (int i = 0; i < 16; i++) begin
      case (kind)
        0: off = 0;
        1: off = 0;
        2: off = int'($urandom_range(0, 255)) - 128;
        3: off = int'($urandom_range(0, 65535)) - 32768;
        4: off = int'($urandom_range(0, 400)) - 200;
        5: off = int'($urandom_range(0, 70000)) - 35000;
        default: off = int'($urandom);
      endcase
      l[32*i +: 32] = (kind == 0) ? 32'd0 : ((i == 0) ? base : base + 32'(off));
    end
    return l;
  endfunction

  function automatic logic [511:0] fill(input logic [31:0] w);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = w;
    return l;
  endfunction

  task automatic send(input logic [511:0] line, input logic [63:0] tag, input bit junk);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL in_ready_timeout got in_ready=%0b required 1 within 400 cycles", in_ready);
      return;
    end
    in_line  = line;
    in_tag   = tag;
    in_valid = 1'b1;
    exp_q.push_back('{d: model(line), tag: tag});
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    if (junk) begin
      // Offers during SCAN must be ignored.
      for (int k = 0; k < 5; k++) begin
        in_line = rand_line();
        in_tag  = {$urandom, $urandom};
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL in_ready_scan got %0b required 0", in_ready);
        end
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending lines required 0", exp_q.size());
    end
  endtask

  // Monitor: latency on each rising out_valid, contents on each handshake.
  initial begin
    bit   prev_v;
    exp_t e;
    int   a;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (out_valid && !prev_v) begin
          checks++;
          if (acc_q.size() == 0) begin
            failures++;
            $display("FAIL latency got out_valid with no accepted line required none");
          end else begin
            a = acc_q.pop_front();
            if (cyc - a != 16) begin
              failures++;
              $display("FAIL latency got %0d cycles required 16", cyc - a);
            end
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output got out_d=%h required no output", out_d);
          end else begin
            e = exp_q.pop_front();
            if (out_d !== e.d) begin
              failures++;
              $display("FAIL out_d got=%h required=%h", out_d, e.d);
            end
            checks++;
            if (out_tag !== e.tag) begin
              failures++;
              $display("FAIL out_tag got=%h required=%h", out_tag, e.tag);
            end
          end
        end
      end
      prev_v = out_valid;
    end
  end

  initial begin
    logic [511:0] l;
    logic [643:0] d0;
    int           n;
    checks     = 0;
    failures   = 0;
    force_mode = 1'b1;
    force_val  = 1'b0;
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_line    = '0;
    in_tag     = '0;

    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %0b required 0", out_valid); end
    checks++;
    if (out_d !== '0) begin failures++; $display("FAIL reset_out_d got %h required 0", out_d); end
    checks++;
    if (out_tag !== '0) begin failures++; $display("FAIL reset_out_tag got %h required 0", out_tag); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %0b required 1", in_ready); end

    force_mode = 1'b0;

    // Directed patterns.
    send('0, 64'hAAAAAAAAAAAAAAA0, 1'b0);
    send(fill(32'h55555555), 64'h1111_2222_3333_4444, 1'b0);
    for (int i = 0; i < 16; i++) l[32*i +: 32] = 32'h1000_0000 + 32'(i) - 32'd3;
    send(l, 64'h0123_4567_89AB_CDEF, 1'b1);
    l = fill(32'h0000_1000); l[32*5 +: 32] = 32'h0000_1000 - 32'd128;
    send(l, 64'd1, 1'b0);
    l = fill(32'h0000_1000); l[32*9 +: 32] = 32'h0000_1000 + 32'd127;
    send(l, 64'd2, 1'b0);
    l = fill(32'h0000_1000); l[32*7 +: 32] = 32'h0000_1000 + 32'd128;
    send(l, 64'd3, 1'b0);
    l = fill(32'h0000_1000); l[32*3 +: 32] = 32'h0000_1000 - 32'd32768;
    send(l, 64'd4, 1'b0);
    l = fill(32'h0000_1000); l[32*15 +: 32] = 32'h0000_1000 + 32'd32767;
    send(l, 64'd5, 1'b0);
    l = fill(32'h0000_1000); l[32*15 +: 32] = 32'h0000_1000 + 32'd32768;
    send(l, 64'd6, 1'b1);
    drain();

    // Backpressure: outputs frozen while out_ready is low.
    force_mode = 1'b1;
    force_val  = 1'b0;
    @(posedge clk);
    #2;
    send(fill(32'hDEAD_BEEF) ^ {480'd0, 32'h1}, 64'hFEED_0000_0000_0001, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    d0 = out_d;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_d !== d0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold got valid=%0b in_ready=%0b d_stable=%0b required 1 0 1",
                 out_valid, in_ready, out_d === d0);
      end
    end
    @(posedge clk);
    force_val = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL release got valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    end
    force_mode = 1'b0;
    drain();

    // Asynchronous reset mid-scan at idx 7; the aborted line must vanish.
    send(rand_line(), 64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
    repeat (7) @(posedge clk);
    #2;
    reset_n = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    if (acc_q.size() != 0) void'(acc_q.pop_back());
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_d !== '0 || out_tag !== '0) begin
      failures++;
      $display("FAIL midreset got valid=%0b d_zero=%0b tag=%h required 0 1 0",
               out_valid, out_d === '0, out_tag);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got in_ready=%0b valid=%0b required 1 0", in_ready, out_valid);
    end
    send(fill(32'h7777_0001), 64'h0000_0000_0000_0777, 1'b0);
    drain();

    // Randomized lines with random consumer readiness.
    for (int t = 0; t < 30; t++) begin
      send(rand_line(), {$urandom, $urandom}, ($urandom_range(0, 1) == 1));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
